simon_job_scheduler: RTL and testbench

SIMON_JOB_SCHEDULER -- requirements
Module: simon_job_scheduler

---
 rtl/simon_job_scheduler.sv | 132 +++++++++++++
 tb/tb_simon_job_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_job_scheduler.sv
// Two-requester job scheduler for a shared SIMON cipher core.
// Round-robin grant, one job in flight, WAIT timeout abort.
module simon_job_scheduler #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_dir,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_dir,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        core_en,
  output logic        core_dir,
  output logic [31:0] core_data,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             dir_q, dir_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic accept;
  logic grant1;

  // last_q holds the last served requester; the other one wins a tie
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
  assign accept = (state_q == IDLE) & (req0_valid | req1_valid);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    data_d  = data_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant1;
          dir_d   = grant1 ? req1_dir : req0_dir;
          data_d  = grant1 ? req1_data : req0_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          rdata_d = core_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready  = accept & ~grant1;
  assign req1_ready  = accept & grant1;
  assign core_en     = (state_q == ISSUE);
  assign core_dir    = dir_q;
  assign core_data   = data_q;
  assign resp0_valid = (state_q == RESP) & ~owner_q;
  assign resp1_valid = (state_q == RESP) & owner_q;
  assign resp_data   = rdata_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_simon_job_scheduler.sv
// Randomized bench for simon_job_scheduler against a job-level
// reference model and a behavioural core stub with set latency.
module tb_simon_job_scheduler;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_dir, req0_ready;
  logic        req1_valid, req1_dir, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        resp0_valid, resp1_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        core_en, core_dir, core_done;
  logic [31:0] core_data, core_result;
  logic        busy;

  simon_job_scheduler #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dir(req0_dir),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .core_en(core_en),
    .core_dir(core_dir), .core_data(core_data),
    .core_done(core_done), .core_result(core_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // core stub: done appears dly cycles into WAIT (0 = first WAIT cycle)
  logic        stub_fix_en = 1'b0;
  logic [31:0] stub_fix = '0;
  int          stub_delay = 0;
  logic        st_armed = 1'b0;
  int          st_left = 0;
  logic [31:0] st_data = '0;
  logic        st_dir = 1'b0;

  function automatic logic [31:0] f_ref(input logic [31:0] d,
                                        input logic dr);
    if (stub_fix_en) return stub_fix;
    if (dr) return d - 32'h1234_5678;
    return {d[15:0], d[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge clk) begin
    if (core_en) begin
      st_armed <= 1'b1;
      st_left  <= stub_delay;
      st_data  <= core_data;
      st_dir   <= core_dir;
    end else if (st_armed) begin
      if (st_left == 0) st_armed <= 1'b0;
      else st_left <= st_left - 1;
    end
  end

  assign core_done = st_armed && (st_left == 0);
  always_comb begin
    core_result = 32'hDEAD_BEEF;
    if (core_done) core_result = f_ref(st_data, st_dir);
  end

  logic m_last = 1'b1;

  task automatic do_job(input logic v0, input logic v1,
                        input logic dr0, input logic dr1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int dly, input int bp);
    logic g, edir, ee;
    logic [31:0] ed, er;
    int n, lat;
    g    = (v0 && v1) ? ~m_last : v1;
    ed   = g ? d1 : d0;
    edir = g ? dr1 : dr0;
    ee   = (dly > TMO - 1);
    er   = ee ? 32'h0 : f_ref(ed, edir);
    lat  = (ee ? TMO - 1 : dly) + 2;
    stub_delay = dly;
    resp_ready = 1'b0;
    req0_valid = v0; req0_dir = dr0; req0_data = d0;
    req1_valid = v1; req1_dir = dr1; req1_data = d1;
    #1;
    chk("rdy0", req0_ready, !g);
    chk("rdy1", req1_ready, g);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    if (g) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    chk("issue_en", core_en, 1);
    chk("issue_data", core_data, ed);
    chk("issue_dir", core_dir, edir);
    chk("issue_busy", busy, 1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (resp0_valid || resp1_valid) break;
      chk("wait_en", core_en, 0);
      chk("wait_data", core_data, ed);
      chk("wait_rdy", req0_ready | req1_ready, 0);
    end
    if (!(resp0_valid || resp1_valid)) begin
      chk("resp_seen", 0, 1);
      return;
    end
    chk("lat", n, lat);
    chk("rv0", resp0_valid, !g);
    chk("rv1", resp1_valid, g);
    chk("rdata", resp_data, er);
    chk("rerr", resp_err, ee);
    chk("resp_dir", core_dir, edir);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_v", g ? resp1_valid : resp0_valid, 1);
      chk("bp_d", resp_data, er);
      chk("bp_busy", busy, 1);
      chk("bp_rdy", req0_ready | req1_ready, 0);
    end
    resp_ready = 1'b1;
    #1;
    chk("resp_noacc", req0_ready | req1_ready, 0);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_rv", resp0_valid | resp1_valid, 0);
    m_last = g;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_dir = 0; req0_data = '0;
    req1_valid = 0; req1_dir = 0; req1_data = '0;
    resp_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", core_en, 0);
    chk("rst_rv", resp0_valid | resp1_valid, 0);
    chk("rst_rdata", resp_data, 0);
    rst = 1'b0;
    @(negedge clk);

    stub_fix_en = 1'b1;
    stub_fix    = 32'hC69B_E9BB;
    do_job(1, 0, 0, 0, 32'h6565_6877, 32'h0, 2, 0);
    stub_fix_en = 1'b0;

    repeat (4)
      do_job(1, 1, 0, 1, $urandom, $urandom, 1, 0);

    do_job(0, 1, 0, 0, 32'h0, $urandom, 1000, 0);
    do_job(0, 1, 0, 1, 32'h0, $urandom, 1, 0);
    do_job(0, 1, 0, 1, 32'h0, 32'h1357_9BDF, 3, 10);
    do_job(1, 0, 1, 0, 32'hCAFE_F00D, 32'h0, 0, 0);
    do_job(1, 0, 0, 0, $urandom, 32'h0, TMO - 1, 1);

    stub_delay = 6;
    req1_valid = 1; req1_dir = 1; req1_data = 32'hFFFF_0001;
    @(negedge clk);
    req1_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_en", core_en, 0);
    chk("mrst_dir", core_dir, 0);
    chk("mrst_data", core_data, 0);
    chk("mrst_rdata", resp_data, 0);
    chk("mrst_err", resp_err, 0);
    chk("mrst_rv", resp0_valid | resp1_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("late_busy", busy, 0);
      chk("late_rv", resp0_valid | resp1_valid, 0);
    end
    do_job(1, 1, 0, 0, $urandom, $urandom, 1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      do_job(r[0], r[1], 1'($urandom), 1'($urandom),
             $urandom, $urandom,
             $urandom_range(0, 10), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
